// File: rtl/bcd_down_timer.sv
// bcd_down_timer: multi-digit BCD countdown timer.
// A packed BCD preset is loaded through a valid/ready handshake. While
// running, each tick strobe decrements the count by one BCD step. Reaching
// zero raises a single-cycle done pulse.
module bcd_down_timer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic                  load_error,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           running_q;

    logic           load_accept;
    logic           preset_ok;
    logic           count_is_zero;
    logic           count_is_one;
    logic [W-1:0]   count_dec;

    // True when every nibble of the value is a legal decimal digit.
    function automatic logic bcd_is_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // BCD subtract-one: zero digits become 9 and pass the borrow upward;
    // the first nonzero digit absorbs it and higher digits are untouched.
    function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Handshake readiness is a pure decode of the state register, so an
    // asynchronous reset raises it immediately.
    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            S_IDLE, S_ARMED, S_EXPIRED: load_ready = 1'b1;
            default:                    load_ready = 1'b0;
        endcase
    end

    // Derived conditions used by the next-state logic.
    always_comb begin
        load_accept   = load_valid & load_ready;
        preset_ok     = bcd_is_valid(load_value);
        count_is_zero = (count_q == '0);
        count_is_one  = (count_q == W'(1));
        count_dec     = bcd_decrement(count_q);
    end

    // Next-state, next-count and pulse generation.
    // A handshake in ARMED (accepted or rejected) takes precedence over start.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (load_accept) begin
            if (preset_ok) begin
                count_d = load_value;
                state_d = S_ARMED;
            end else begin
                // Back-to-back rejects must not stretch the error pulse.
                err_d = ~err_q;
            end
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (start) begin
                        if (count_is_zero) begin
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else if (tick) begin
                        count_d = count_dec;
                        if (count_is_one) begin
                            state_d = S_EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, count and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            err_q     <= err_d;
            running_q <= (state_d == S_RUN);
        end
    end

    // Output port drive.
    always_comb begin
        count      = count_q;
        running    = running_q;
        done       = done_q;
        load_error = err_q;
    end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Multi-digit BCD down counter (countdown timer): the decrementing counterpart of the team's BCD up counter. Loads a packed BCD preset through a valid/ready handshake and decrements by one BCD count per tick strobe while running. Flags expiry with a single-cycle done pulse. Sits beside the up counter in display/timer datapaths and feeds the same 7-segment digit drivers.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS bits, digit 0 is the least significant nibble.

Ports:
clock  input  1  system clock; all logic is rising-edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  preset offered on load_value.
load_ready  output  1  block can accept a preset this cycle.
load_value  input  4*DIGITS  packed BCD preset.
load_error  output  1  one-cycle pulse; the offered preset contained a nibble greater than 9 and was rejected.
start  input  1  begin counting from ARMED.
pause  input  1  level; holds the count while high.
tick  input  1  one-cycle count-enable strobe.
count  output  4*DIGITS  current BCD value (registered).
running  output  1  high only in state RUN.
done  output  1  one-cycle pulse on expiry.

Behaviour:
- Reset (asynchronous, any time including mid-run) forces:
  - state IDLE
  - count 0
  - running 0, done 0, load_error 0
  - load_ready 1
- States: IDLE, ARMED, RUN, PAUSED, EXPIRED.
- load_ready is 1 in IDLE, ARMED and EXPIRED, and 0 in RUN and PAUSED.
- A load is accepted on an edge where load_valid and load_ready are both high:
  - All nibbles ≤9: count takes load_value on that edge and the state goes to ARMED.
  - Any nibble >9: the load is rejected. count and state are unchanged, and load_error pulses high for the next cycle.
  - An all-zero preset is legal.
- ARMED:
  - start=1 with count≠0 goes to RUN on the next edge.
  - start=1 with count=0 goes to EXPIRED, and done pulses for the next cycle.
  - A new load while ARMED replaces the preset. If load and start are high on the same edge, the load wins and start is ignored.
- RUN:
  - pause=1 goes to PAUSED. pause takes priority over tick, so a tick in that cycle does not decrement.
  - Otherwise, tick=1 decrements count by one in BCD:
    - digit 0 decrements;
    - any digit at 0 becomes 9 and borrows from the next digit;
    - digits above the first nonzero digit are unchanged.
  - A tick with count=1 makes count 0 and moves to EXPIRED on the same edge. done is high for exactly the one cycle following that edge.
  - start and load_valid are ignored in RUN.
- PAUSED:
  - count holds and tick is ignored.
  - pause=0 returns to RUN on the next edge.
  - Ticks are not counted during the return cycle (the state is still PAUSED).
- EXPIRED:
  - count holds at 0 and never wraps; tick and start are ignored.
  - An accepted load goes to ARMED.
- IDLE: only a load has effect.
- Output timing:
  - running is registered and equals (state==RUN).
  - done and load_error are registered, never high for two consecutive cycles, and cleared by reset.
- Latency:
  - count reflects a tick one edge after the tick is sampled.
  - The first decrement can occur on the edge after entering RUN.
- Every count value ever presented is valid BCD.

Test Plan:
1. Reset, then load 0x0012 and start, then 12 ticks spaced 3 cycles apart -> count sequence 0012, 0011, 0010, 0009, ..., 0000. done pulses for exactly 1 cycle after the 12th tick, state EXPIRED, further ticks leave count 0000.
2. Multi-digit borrow: load 0x1000, start, 1 tick -> count 0999. One more tick -> 0998.
3. Invalid preset 0x00A5 offered in IDLE -> load_error 1 for one cycle, count stays 0000, load_ready stays 1. Then load 0x0005 -> accepted, ARMED.
4. Pause priority: running at 0050, pause and tick high on the same edge -> count stays 0050 and state PAUSED. 5 ticks while paused -> still 0050. Release pause, then 1 tick -> 0049.
5. Load in RUN: load_valid with 0x0099 while running -> load_ready 0, count unaffected. Load of 0x0000 then start -> EXPIRED with one done pulse and no ticks needed.
6. Asynchronous reset asserted between clock edges mid-run at 0437 -> count 0000, running 0 and load_ready 1 immediately, without waiting for a clock edge. After reset release, ticks do not change count.
